// File: rtl/game_ctrl.sv
// Flappy-bird game sequencer: debounces the flap button, paces flaps,
// runs IDLE/PLAYING/DYING/GAME_OVER and keeps the score.
// Ports:
//   i_clk, i_rst_n (async, active-low)
//   i_ani_stb, i_physics_stb: frame and physics strobes
//   i_btn: raw flap button
//   i_out_of_bounds, i_collide, i_pipe_passed: bird/pipe events
//   o_bird_rst, o_animate, o_flap: bird and pipe block controls
//   o_state, o_score: game state and score
//   o_hiscore: best score, only when GAME_CTRL_HISCORE_EN is defined
module game_ctrl #(
  parameter int DB_CYC       = 250000,
  parameter int FLAP_GAP     = 4,
  parameter int DEATH_FRAMES = 60,
  parameter int SCORE_W      = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ani_stb,
  input  logic               i_physics_stb,
  input  logic               i_btn,
  input  logic               i_out_of_bounds,
  input  logic               i_collide,
  input  logic               i_pipe_passed,
  output logic               o_bird_rst,
  output logic               o_animate,
  output logic               o_flap,
  output logic [1:0]         o_state,
  output logic [SCORE_W-1:0] o_score
`ifdef GAME_CTRL_HISCORE_EN
  ,
  output logic [SCORE_W-1:0] o_hiscore
`endif
);

  localparam int DB_W  = $clog2(DB_CYC + 1);
  localparam int GAP_W = $clog2(FLAP_GAP + 1);
  localparam int FRM_W = $clog2(DEATH_FRAMES + 1);

  localparam logic [DB_W-1:0]    DB_LAST  = DB_W'(DB_CYC - 1);
  localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(FLAP_GAP);
  localparam logic [FRM_W-1:0]   FRM_LAST = FRM_W'(DEATH_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PLAYING = 2'd1;
  localparam logic [1:0] S_DYING   = 2'd2;
  localparam logic [1:0] S_OVER    = 2'd3;

  logic               btn_s1;
  logic               btn_s2;
  logic               db_lvl;
  logic               db_prev;
  logic [DB_W-1:0]    db_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [FRM_W-1:0]   frm_cnt;
  logic               press;

  logic [1:0]         st_nxt;
  logic               flap_nxt;
  logic [SCORE_W-1:0] score_nxt;
  logic [FRM_W-1:0]   frm_nxt;
  logic [GAP_W-1:0]   gap_nxt;

  // Debounced level only moves after DB_CYC cycles of disagreement.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      db_lvl  <= 1'b0;
      db_prev <= 1'b0;
      db_cnt  <= '0;
    end else begin
      btn_s1  <= i_btn;
      btn_s2  <= btn_s1;
      db_prev <= db_lvl;
      if (btn_s2 == db_lvl) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_lvl <= btn_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press = db_lvl & ~db_prev;

  always_comb begin
    st_nxt    = o_state;
    flap_nxt  = 1'b0;
    score_nxt = o_score;
    frm_nxt   = frm_cnt;
    unique case (1'b1)
      (o_state == S_IDLE): begin
        if (press) begin
          st_nxt    = S_PLAYING;
          score_nxt = '0;
          flap_nxt  = 1'b1;
        end
      end
      (o_state == S_PLAYING): begin
        // A hit wins over anything else happening this cycle.
        if (i_collide || i_out_of_bounds) begin
          st_nxt  = S_DYING;
          frm_nxt = '0;
        end else begin
          if (press && gap_cnt == '0) flap_nxt = 1'b1;
          if (i_pipe_passed && o_score != SCORE_MAX)
            score_nxt = o_score + 1'b1;
        end
      end
      (o_state == S_DYING): begin
        if (i_ani_stb) begin
          if (frm_cnt == FRM_LAST) st_nxt = S_OVER;
          else frm_nxt = frm_cnt + 1'b1;
        end
      end
      (o_state == S_OVER): begin
        if (press) st_nxt = S_IDLE;
      end
      default: ;
    endcase
  end

  // A fresh load takes priority over a coincident physics strobe.
  always_comb begin
    gap_nxt = gap_cnt;
    if (flap_nxt) gap_nxt = GAP_LOAD;
    else if (i_physics_stb && gap_cnt != '0) gap_nxt = gap_cnt - 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_state    <= S_IDLE;
      o_flap     <= 1'b0;
      o_score    <= '0;
      o_bird_rst <= 1'b1;
      o_animate  <= 1'b0;
      gap_cnt    <= '0;
      frm_cnt    <= '0;
    end else begin
      o_state    <= st_nxt;
      o_flap     <= flap_nxt;
      o_score    <= score_nxt;
      o_bird_rst <= (st_nxt == S_IDLE);
      o_animate  <= (st_nxt == S_PLAYING);
      gap_cnt    <= gap_nxt;
      frm_cnt    <= frm_nxt;
    end
  end

`ifdef GAME_CTRL_HISCORE_EN
  logic died;

  // Score is frozen in DYING, so compare one cycle after the hit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      died      <= 1'b0;
      o_hiscore <= '0;
    end else begin
      died <= (o_state == S_PLAYING) && (st_nxt == S_DYING);
      if (died && o_score > o_hiscore) o_hiscore <= o_score;
    end
  end
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: debounce, flap pacing, scoring,
// saturation (second narrow instance), death sequence, reset, hiscore.
module tb_game_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, ani, phys, btn, oob, coll, pipe;
  logic bird_rst, animate, flap;
  logic [1:0] state;
  logic [7:0] score;
  logic bird_rst2, animate2, flap2;
  logic [1:0] state2;
  logic [1:0] score2;
`ifdef GAME_CTRL_HISCORE_EN
  logic [7:0] hi;
  logic [1:0] hi2;
`endif

  game_ctrl #(
    .DB_CYC(4), .FLAP_GAP(4), .DEATH_FRAMES(3), .SCORE_W(8)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ani_stb(ani),
    .i_physics_stb(phys), .i_btn(btn), .i_out_of_bounds(oob),
    .i_collide(coll), .i_pipe_passed(pipe),
    .o_bird_rst(bird_rst), .o_animate(animate), .o_flap(flap),
    .o_state(state), .o_score(score)
`ifdef GAME_CTRL_HISCORE_EN
    , .o_hiscore(hi)
`endif
  );

  game_ctrl #(
    .DB_CYC(4), .FLAP_GAP(4), .DEATH_FRAMES(3), .SCORE_W(2)
  ) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ani_stb(ani),
    .i_physics_stb(phys), .i_btn(btn), .i_out_of_bounds(oob),
    .i_collide(coll), .i_pipe_passed(pipe),
    .o_bird_rst(bird_rst2), .o_animate(animate2), .o_flap(flap2),
    .o_state(state2), .o_score(score2)
`ifdef GAME_CTRL_HISCORE_EN
    , .o_hiscore(hi2)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int nf, first;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_press(input bit stb_flap, output int nflap,
                          output int fst);
    nflap = 0;
    fst   = 0;
    btn   = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 11) btn = 1'b0;
      phys = stb_flap && (k == 7);
      tick();
      if (flap) begin
        nflap++;
        if (fst == 0) fst = k;
      end
    end
    phys = 1'b0;
  endtask

  task automatic strobe_phys();
    phys = 1'b1; tick(); phys = 1'b0; tick();
  endtask

  task automatic strobe_ani();
    ani = 1'b1; tick(); ani = 1'b0; tick();
  endtask

  task automatic pulse_pipe();
    pipe = 1'b1; tick(); pipe = 1'b0; tick();
  endtask

`ifdef GAME_CTRL_HISCORE_EN
  task automatic play_game(input int n);
    int a, b;
    do_press(1'b0, a, b);
    for (int i = 0; i < n; i++) pulse_pipe();
    oob = 1'b1; tick(); oob = 1'b0;
    tick(); tick();
    for (int i = 0; i < 3; i++) strobe_ani();
    do_press(1'b0, a, b);
  endtask
`endif

  initial begin
    rst_n = 1'b0; ani = 1'b0; phys = 1'b0; btn = 1'b0;
    oob = 1'b0; coll = 1'b0; pipe = 1'b0;
    tick(); tick(); tick();
    check("rst_state", 32'(state), 0);
    check("rst_bird_rst", 32'(bird_rst), 1);
    check("rst_animate", 32'(animate), 0);
    check("rst_flap", 32'(flap), 0);
    check("rst_score", 32'(score), 0);
    rst_n = 1'b1;
    tick();

    // glitch of two cycles must not reach the debounced level
    nf = 0;
    btn = 1'b1; tick(); tick(); btn = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (flap) nf++;
    end
    check("glitch_state", 32'(state), 0);
    check("glitch_flap", 32'(nf), 0);

    // start: flap seen 7 cycles after the rise, exactly once
    do_press(1'b0, nf, first);
    check("start_nflap", 32'(nf), 1);
    check("start_latency", 32'(first), 7);
    check("start_state", 32'(state), 1);
    check("start_bird_rst", 32'(bird_rst), 0);
    check("start_animate", 32'(animate), 1);

    // flap pacing
    for (int i = 0; i < 4; i++) strobe_phys();
    do_press(1'b1, nf, first);
    check("gap_p1", 32'(nf), 1);
    strobe_phys();
    do_press(1'b0, nf, first);
    check("gap_p2", 32'(nf), 0);
    strobe_phys();
    do_press(1'b0, nf, first);
    check("gap_p3", 32'(nf), 0);
    strobe_phys();
    do_press(1'b0, nf, first);
    check("gap_p4_coincident", 32'(nf), 0);
    strobe_phys();
    do_press(1'b0, nf, first);
    check("gap_p5", 32'(nf), 1);

    // scoring and saturation
    for (int i = 0; i < 3; i++) pulse_pipe();
    check("score3", 32'(score), 3);
    check("score3_w2", 32'(score2), 3);
    pulse_pipe(); pulse_pipe();
    check("score5", 32'(score), 5);
    check("score_sat_w2", 32'(score2), 3);

    // async reset mid-game
    rst_n = 1'b0;
    #2;
    check("arst_state", 32'(state), 0);
    check("arst_bird_rst", 32'(bird_rst), 1);
    check("arst_animate", 32'(animate), 0);
    check("arst_score", 32'(score), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // collision with coincident pipe pass
    do_press(1'b0, nf, first);
    check("g2_state", 32'(state), 1);
    pulse_pipe(); pulse_pipe();
    check("g2_score", 32'(score), 2);
    pipe = 1'b1; coll = 1'b1; tick(); pipe = 1'b0; coll = 1'b0;
    check("hit_state", 32'(state), 2);
    check("hit_score", 32'(score), 2);
    check("hit_animate", 32'(animate), 0);
    coll = 1'b1; tick(); coll = 1'b0;
    check("dying_coll_ign", 32'(state), 2);
    do_press(1'b0, nf, first);
    check("dying_press_flap", 32'(nf), 0);
    check("dying_press_state", 32'(state), 2);
    strobe_ani(); strobe_ani();
    check("dying_2frm", 32'(state), 2);
    strobe_ani();
    check("over_state", 32'(state), 3);
    check("over_score", 32'(score), 2);
    do_press(1'b0, nf, first);
    check("idle_state", 32'(state), 0);
    check("idle_score_kept", 32'(score), 2);
    check("idle_bird_rst", 32'(bird_rst), 1);
    do_press(1'b0, nf, first);
    check("g3_state", 32'(state), 1);
    check("g3_score_clr", 32'(score), 0);
    check("g3_flap", 32'(nf), 1);

    // out of bounds
    oob = 1'b1; tick(); oob = 1'b0;
    check("oob_state", 32'(state), 2);
    strobe_ani(); strobe_ani(); strobe_ani();
    check("oob_over", 32'(state), 3);

`ifdef GAME_CTRL_HISCORE_EN
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    check("hi_rst", 32'(hi), 0);
    play_game(4);
    play_game(2);
    check("hi_after2", 32'(hi), 4);
    play_game(6);
    check("hi_after3", 32'(hi), 6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Top-level game sequencer for the flappy-bird datapath.
- Conditions the raw flap button and converts it into single-cycle flap pulses for the bird physics block.
- Drives that block's reset and animate enables, and tracks game state and score.
- Collision, out-of-bounds and pipe-passed events come back from the bird and pipe blocks; state and score go to the renderer and score display.

Parameters:
- DB_CYC, 250000, debounce window in i_clk cycles; button must be stable this long before the debounced level changes.
- FLAP_GAP, 4, minimum number of i_physics_stb strobes between two accepted flaps.
- DEATH_FRAMES, 60, number of i_ani_stb strobes spent in DYING before GAME_OVER.
- SCORE_W, 8, score counter width.

Ports:
- i_clk  in  1  base clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_ani_stb  in  1  one-cycle frame strobe.
- i_physics_stb  in  1  one-cycle physics strobe.
- i_btn  in  1  raw, asynchronous flap button.
- i_out_of_bounds  in  1  bird out-of-bounds level.
- i_collide  in  1  bird/pipe overlap level.
- i_pipe_passed  in  1  one-cycle pulse when the bird clears a pipe.
- o_bird_rst  out  1  reset to the bird block, level.
- o_animate  out  1  animate enable to the bird and pipe blocks.
- o_flap  out  1  one-cycle flap pulse.
- o_state  out  2  0=IDLE, 1=PLAYING, 2=DYING, 3=GAME_OVER.
- o_score  out  SCORE_W  current score.

Behaviour:
- Reset: i_rst_n low asynchronously clears all state. Outputs while in reset:
  - o_state=IDLE, o_bird_rst=1, o_animate=0, o_flap=0, o_score=0.
  - Synchronizer and debounce state: debounced level=0, debounce counter=0, gap counter=0.
- Button conditioning:
  - i_btn passes through a 2-FF synchronizer.
  - Debounce counter resets whenever the synchronized level differs from the debounced level.
  - Debounced level takes the new value when the counter reaches DB_CYC-1.
  - A press event is a debounced 0->1 edge, one cycle wide.
  - Latency from a stable i_btn change to press = 2 + DB_CYC cycles.
- Flap gap counter:
  - Loads FLAP_GAP on every emitted flap.
  - Decrements on each i_physics_stb while nonzero.
  - A press with gap counter nonzero is dropped, not queued.
- All outputs are registered.

State machine:
- IDLE:
  - o_bird_rst=1, o_animate=0.
  - On press: go to PLAYING, clear o_score, emit o_flap on the cycle after the transition.
- PLAYING:
  - o_bird_rst=0, o_animate=1.
  - Press with gap counter==0 emits o_flap the next cycle.
  - i_pipe_passed increments o_score, saturating at all-ones.
  - i_collide or i_out_of_bounds high on any cycle: go to DYING next cycle. Same-cycle i_pipe_passed is ignored (no increment) and a same-cycle press emits no flap.
- DYING:
  - o_animate=0, o_flap never asserted.
  - Frame counter counts i_ani_stb; after DEATH_FRAMES strobes go to GAME_OVER.
  - Presses are ignored.
- GAME_OVER:
  - o_animate=0; o_score holds.
  - On press: go to IDLE. Score is cleared only on the next IDLE->PLAYING.

Boundary conditions:
- o_flap is never high two consecutive cycles.
- i_physics_stb on the same cycle o_flap is emitted does not decrement the freshly loaded gap counter.
- Collision inputs are ignored outside PLAYING.
- A button held across a state change generates no new press.

Optional Feature:
- Macro: GAME_CTRL_HISCORE_EN.
- Defined:
  - Adds output o_hiscore (SCORE_W bits), reset 0.
  - On the PLAYING->DYING transition, o_hiscore <= max(o_hiscore, o_score), visible the cycle after entering DYING.
  - Survives game restarts; cleared only by i_rst_n.
- Undefined: port absent, no comparator logic.

Test Plan:
- Reset, DB_CYC=4: drive i_rst_n low mid-PLAYING with score 5 -> immediately o_state=0, o_bird_rst=1, o_animate=0, o_score=0.
- Debounce, DB_CYC=4: i_btn glitches high 2 cycles -> no state change. i_btn high 10 cycles in IDLE -> o_state=1 and a single o_flap pulse, first seen 6 cycles after the rise plus the registered-output delay.
- Flap gap, FLAP_GAP=4: three presses spaced 1 physics strobe apart in PLAYING -> only the first produces o_flap. A press after 4 strobes -> o_flap.
- Scoring: 3 i_pipe_passed pulses -> o_score=3. With SCORE_W=2, 5 pulses -> o_score=3 (saturated). i_pipe_passed coincident with i_collide -> no increment, o_state=2.
- Death sequence, DEATH_FRAMES=3: i_out_of_bounds high in PLAYING -> o_state=2 next cycle. After 3 i_ani_stb -> o_state=3. Press -> o_state=0 with o_score retained. Next press -> o_state=1, o_score=0.
- With GAME_CTRL_HISCORE_EN: game 1 scores 4, game 2 scores 2 -> o_hiscore=4 after both deaths. Game 3 scores 6 -> o_hiscore=6.
